// File: rtl/pipe_decode_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_decode_stage_if
// ID/EX pipeline-register bundle handed from the decode stage to the EX stage.
//   master : driven by pipe_decode_stage (registered ID/EX contents)
//   slave  : consumed by the EX stage
// Fields:
//   ewreg/em2reg/ewmem/ealuimm/eshift/ejal : EX control bits
//   ealuc : ALU op, ern : destination register
//   ea/eb : operand values, eimm : extended immediate, epc4 : PC+4
// -----------------------------------------------------------------------------
interface pipe_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            ewreg;
    logic            em2reg;
    logic            ewmem;
    logic            ealuimm;
    logic            eshift;
    logic            ejal;
    logic [3:0]      ealuc;
    logic [4:0]      ern;
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] eb;
    logic [XLEN-1:0] eimm;
    logic [XLEN-1:0] epc4;

    modport master (
        output ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
        output ealuc, ern, ea, eb, eimm, epc4
    );

    modport slave (
        input ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
        input ealuc, ern, ea, eb, eimm, epc4
    );
endinterface

// File: rtl/pipe_decode_stage.sv
// -----------------------------------------------------------------------------
// pipe_decode_stage
// Instruction-decode stage of the five-stage MIPS-subset pipeline. Reads the
// integrated 32-entry register file, forwards from EX/MEM, detects load-use /
// RAW interlocks, resolves branches and jumps in ID and holds the ID/EX
// pipeline register. A saturating counter records stalled cycles.
// Ports:
//   clock, resetn          : clock, asynchronous active-low reset
//   dpc4, inst, c*         : ID instruction, PC+4 and pre-decoded controls
//   ealu                   : EX-stage ALU result (combinational)
//   mrn/mwreg/mm2reg/malu/mmo : MEM-stage state
//   wrn/wwreg/wdi          : writeback port
//   bpc/jpc/rpc/pcsource   : next-PC targets and selector
//   wpcir, dflush          : IF/ID freeze and flush
//   idex (master)          : registered ID/EX bundle
//   stall_cnt              : stalled-cycle counter
// -----------------------------------------------------------------------------
module pipe_decode_stage #(
    parameter int XLEN        = 32,
    parameter bit FWD_EN      = 1'b1,
    parameter bit BRANCH_SLOT = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [XLEN-1:0]  dpc4,
    input  logic [31:0]      inst,
    input  logic             cwreg,
    input  logic             cm2reg,
    input  logic             cwmem,
    input  logic             caluimm,
    input  logic             cshift,
    input  logic             cjal,
    input  logic             cusert,
    input  logic             csext,
    input  logic [3:0]       caluc,
    input  logic             cuse_rs,
    input  logic             cuse_rt,
    input  logic             cbeq,
    input  logic             cbne,
    input  logic             cj,
    input  logic             cjr,
    input  logic [XLEN-1:0]  ealu,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [XLEN-1:0]  malu,
    input  logic [XLEN-1:0]  mmo,
    input  logic [4:0]       wrn,
    input  logic             wwreg,
    input  logic [XLEN-1:0]  wdi,
    output logic [XLEN-1:0]  bpc,
    output logic [XLEN-1:0]  jpc,
    output logic [XLEN-1:0]  rpc,
    output logic [1:0]       pcsource,
    output logic             wpcir,
    output logic             dflush,
    pipe_decode_stage_if.master idex,
    output logic [CNT_W-1:0] stall_cnt
);

    // A writer in stage X hits source register src (r0 never hits).
    function automatic logic wr_hit(input logic wen, input logic [4:0] dst, input logic [4:0] src);
        return wen && (dst != 5'd0) && (dst == src);
    endfunction

    logic [XLEN-1:0]  regs_r [32];

    logic             ewreg_r;
    logic             em2reg_r;
    logic             ewmem_r;
    logic             ealuimm_r;
    logic             eshift_r;
    logic             ejal_r;
    logic [3:0]       ealuc_r;
    logic [4:0]       ern_r;
    logic [XLEN-1:0]  ea_r;
    logic [XLEN-1:0]  eb_r;
    logic [XLEN-1:0]  eimm_r;
    logic [XLEN-1:0]  epc4_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic [4:0]       rs_s;
    logic [4:0]       rt_s;
    logic [4:0]       rd_s;
    logic [4:0]       drn_s;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  rf_a_s;
    logic [XLEN-1:0]  rf_b_s;
    logic [XLEN-1:0]  mem_val_s;
    logic [XLEN-1:0]  da_s;
    logic [XLEN-1:0]  db_s;
    logic             ex_hit_a_s;
    logic             ex_hit_b_s;
    logic             mem_hit_a_s;
    logic             mem_hit_b_s;
    logic             stall_s;
    logic             equal_s;
    logic             br_taken_s;
    logic             taken_s;
    logic [1:0]       pcsource_s;
    logic             unused_opcode_s;

    assign rs_s  = inst[25:21];
    assign rt_s  = inst[20:16];
    assign rd_s  = inst[15:11];
    assign drn_s = cjal ? 5'd31 : (cusert ? rt_s : rd_s);
    assign imm_s = csext ? {{(XLEN-16){inst[15]}}, inst[15:0]}
                         : {{(XLEN-16){1'b0}}, inst[15:0]};

    // The opcode field is fully decoded upstream into the c* controls.
    assign unused_opcode_s = &{1'b0, inst[31:26]};

    // Register file write port: falling edge, so a WB write is visible to
    // the ID read later in the same cycle without a dedicated bypass.
    always_ff @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wwreg && (wrn != 5'd0)) begin
            regs_r[wrn] <= wdi;
        end
    end

    assign rf_a_s = (rs_s == 5'd0) ? {XLEN{1'b0}} : regs_r[rs_s];
    assign rf_b_s = (rt_s == 5'd0) ? {XLEN{1'b0}} : regs_r[rt_s];

    assign ex_hit_a_s  = wr_hit(ewreg_r, ern_r, rs_s);
    assign ex_hit_b_s  = wr_hit(ewreg_r, ern_r, rt_s);
    assign mem_hit_a_s = wr_hit(mwreg, mrn, rs_s);
    assign mem_hit_b_s = wr_hit(mwreg, mrn, rt_s);
    assign mem_val_s   = mm2reg ? mmo : malu;

    // Operand selection: EX (non-load) beats MEM beats the register file.
    always_comb begin
        da_s = rf_a_s;
        db_s = rf_b_s;
        if (FWD_EN) begin
            if (ex_hit_a_s && !em2reg_r) begin
                da_s = ealu;
            end else if (mem_hit_a_s) begin
                da_s = mem_val_s;
            end else begin
                da_s = rf_a_s;
            end
            if (ex_hit_b_s && !em2reg_r) begin
                db_s = ealu;
            end else if (mem_hit_b_s) begin
                db_s = mem_val_s;
            end else begin
                db_s = rf_b_s;
            end
        end else begin
            da_s = rf_a_s;
            db_s = rf_b_s;
        end
    end

    // Interlock: with forwarding only an EX load blocks; without it any
    // in-flight EX or MEM writer of a used source register blocks.
    always_comb begin
        stall_s = 1'b0;
        if (FWD_EN) begin
            stall_s = (cuse_rs && ex_hit_a_s && em2reg_r) ||
                      (cuse_rt && ex_hit_b_s && em2reg_r);
        end else begin
            stall_s = (cuse_rs && (ex_hit_a_s || mem_hit_a_s)) ||
                      (cuse_rt && (ex_hit_b_s || mem_hit_b_s));
        end
    end

    assign equal_s    = (da_s == db_s);
    assign br_taken_s = (cbeq && equal_s) || (cbne && !equal_s);
    assign taken_s    = !stall_s && (br_taken_s || cj || cjr);

    // Next-PC selector; a stalled instruction must not redirect fetch.
    always_comb begin
        pcsource_s = 2'b00;
        if (stall_s) begin
            pcsource_s = 2'b00;
        end else if (cjr) begin
            pcsource_s = 2'b10;
        end else if (cj) begin
            pcsource_s = 2'b11;
        end else if (br_taken_s) begin
            pcsource_s = 2'b01;
        end else begin
            pcsource_s = 2'b00;
        end
    end

    assign bpc      = dpc4 + {imm_s[XLEN-3:0], 2'b00};
    assign jpc      = {dpc4[XLEN-1:28], inst[25:0], 2'b00};
    assign rpc      = da_s;
    assign pcsource = pcsource_s;
    assign wpcir    = !stall_s;
    assign dflush   = taken_s && !BRANCH_SLOT;

    // ID/EX pipeline register: a stall inserts an all-zero bubble.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ewreg_r   <= 1'b0;
            em2reg_r  <= 1'b0;
            ewmem_r   <= 1'b0;
            ealuimm_r <= 1'b0;
            eshift_r  <= 1'b0;
            ejal_r    <= 1'b0;
            ealuc_r   <= 4'd0;
            ern_r     <= 5'd0;
            ea_r      <= {XLEN{1'b0}};
            eb_r      <= {XLEN{1'b0}};
            eimm_r    <= {XLEN{1'b0}};
            epc4_r    <= {XLEN{1'b0}};
        end else if (stall_s) begin
            ewreg_r   <= 1'b0;
            em2reg_r  <= 1'b0;
            ewmem_r   <= 1'b0;
            ealuimm_r <= 1'b0;
            eshift_r  <= 1'b0;
            ejal_r    <= 1'b0;
            ealuc_r   <= 4'd0;
            ern_r     <= 5'd0;
            ea_r      <= {XLEN{1'b0}};
            eb_r      <= {XLEN{1'b0}};
            eimm_r    <= {XLEN{1'b0}};
            epc4_r    <= {XLEN{1'b0}};
        end else begin
            ewreg_r   <= cwreg;
            em2reg_r  <= cm2reg;
            ewmem_r   <= cwmem;
            ealuimm_r <= caluimm;
            eshift_r  <= cshift;
            ejal_r    <= cjal;
            ealuc_r   <= caluc;
            ern_r     <= drn_s;
            ea_r      <= da_s;
            eb_r      <= db_s;
            eimm_r    <= imm_s;
            epc4_r    <= dpc4;
        end
    end

    // Stalled-cycle counter, saturating at all-ones.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt    = stall_cnt_r;
    assign idex.ewreg   = ewreg_r;
    assign idex.em2reg  = em2reg_r;
    assign idex.ewmem   = ewmem_r;
    assign idex.ealuimm = ealuimm_r;
    assign idex.eshift  = eshift_r;
    assign idex.ejal    = ejal_r;
    assign idex.ealuc   = ealuc_r;
    assign idex.ern     = ern_r;
    assign idex.ea      = ea_r;
    assign idex.eb      = eb_r;
    assign idex.eimm    = eimm_r;
    assign idex.epc4    = epc4_r;

endmodule
